// File: rtl/pipe_stage_regs.sv
// pipe_stage_regs: PC, IF/ID and ID/EX registers for the 5-stage MIPS front end.
// Applies hazard-unit stall/flush requests and the ID-stage branch decision
// in fixed priority. All outputs are registered.
// Optional feature: define PIPE_PERF_CNT_EN to build the saturating
// stall/bubble performance counters; otherwise both counter ports read 0.
module pipe_stage_regs #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          CTRL_W   = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       pc_next,
  input  logic [31:0]       if_instr,
  input  logic [31:0]       if_pc_plus4,
  input  logic              StallF,
  input  logic              StallD,
  input  logic              FlushE,
  input  logic              id_branch_taken,
  input  logic [CTRL_W-1:0] id_ctrl,
  input  logic [31:0]       id_rd1,
  input  logic [31:0]       id_rd2,
  input  logic [31:0]       id_imm,
  input  logic [4:0]        id_rs_a,
  input  logic [4:0]        id_rt_a,
  input  logic [4:0]        id_rd_a,
  output logic [31:0]       pc,
  output logic [31:0]       id_instr,
  output logic [31:0]       id_pc_plus4,
  output logic              id_valid,
  output logic [CTRL_W-1:0] ex_ctrl,
  output logic [31:0]       ex_rd1,
  output logic [31:0]       ex_rd2,
  output logic [31:0]       ex_imm,
  output logic [4:0]        ex_rs_a,
  output logic [4:0]        ex_rt_a,
  output logic [4:0]        ex_rd_a,
  output logic              ex_valid,
  output logic [31:0]       perf_stall_cycles,
  output logic [31:0]       perf_bubbles
);

  // A taken branch only squashes IF/ID when IF/ID is not being held;
  // a decision made while stalled used stale operands.
  logic flush_d;
  assign flush_d = id_branch_taken && !StallD;

  // Fetch PC: reset, hold on StallF, otherwise follow the PC mux.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc <= RESET_PC;
    end else if (!StallF) begin
      pc <= pc_next;
    end
  end

  // IF/ID: reset > stall hold > branch flush > load.
  always_ff @(posedge clk) begin
    if (rst || (!StallD && id_branch_taken)) begin
      id_instr    <= 32'h0;
      id_pc_plus4 <= 32'h0;
      id_valid    <= 1'b0;
    end else if (!StallD) begin
      id_instr    <= if_instr;
      id_pc_plus4 <= if_pc_plus4;
      id_valid    <= 1'b1;
    end
  end

  // ID/EX: never stalls; a bubble zeroes every field so ex_rd_a=0 cannot
  // match a forwarding compare.
  always_ff @(posedge clk) begin
    if (rst || FlushE) begin
      ex_ctrl  <= '0;
      ex_rd1   <= 32'h0;
      ex_rd2   <= 32'h0;
      ex_imm   <= 32'h0;
      ex_rs_a  <= 5'h0;
      ex_rt_a  <= 5'h0;
      ex_rd_a  <= 5'h0;
      ex_valid <= 1'b0;
    end else begin
      ex_ctrl  <= id_ctrl;
      ex_rd1   <= id_rd1;
      ex_rd2   <= id_rd2;
      ex_imm   <= id_imm;
      ex_rs_a  <= id_rs_a;
      ex_rt_a  <= id_rt_a;
      ex_rd_a  <= id_rd_a;
      ex_valid <= id_valid;
    end
  end

`ifdef PIPE_PERF_CNT_EN
  logic [31:0] stall_cnt;
  logic [31:0] bubble_cnt;

  // Saturating counters; a FlushE and a FlushD on the same edge count once.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt  <= 32'h0;
      bubble_cnt <= 32'h0;
    end else begin
      if (StallF && (stall_cnt != 32'hFFFF_FFFF)) begin
        stall_cnt <= stall_cnt + 32'h1;
      end
      if ((FlushE || flush_d) && (bubble_cnt != 32'hFFFF_FFFF)) begin
        bubble_cnt <= bubble_cnt + 32'h1;
      end
    end
  end

  assign perf_stall_cycles = stall_cnt;
  assign perf_bubbles      = bubble_cnt;
`else
  logic unused_flush_d;
  assign unused_flush_d    = flush_d;
  assign perf_stall_cycles = 32'h0;
  assign perf_bubbles      = 32'h0;
`endif

endmodule

// File: doc/pipe_stage_regs.md
# pipe_stage_regs

Front-end pipeline register bank for the 5-stage MIPS core: holds the PC, the IF/ID register and the ID/EX register. It consumes the stall/flush requests produced by the hazard unit (StallF, StallD, FlushE) and the ID-stage branch decision, and applies them with fixed priority. It is the stall/flush responder for that unit. Its ID/EX outputs feed the execute stage and the hazard unit's ex_* address inputs.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on reset
- CTRL_W, 8, width of the opaque decoded control bundle (RegWrite, MemToReg, MemWrite, ...); all-zero means no side effects

- clk  in  1  clock, all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- pc_next  in  32  next-PC from the PC mux
- if_instr, if_pc_plus4  in  32 each  fetched instruction and PC+4
- StallF, StallD, FlushE  in  1 each  hazard-unit requests
- id_branch_taken  in  1  branch resolved taken in ID (PCSrc); generates FlushD
- id_ctrl  in  CTRL_W  decoded control
- id_rd1, id_rd2, id_imm  in  32 each  register operands and sign-extended immediate
- id_rs_a, id_rt_a, id_rd_a  in  5 each  register addresses (id_rd_a is the post-RegDst destination)
- pc  out  32  current fetch PC
- id_instr, id_pc_plus4  out  32 each  IF/ID contents
- id_valid  out  1  IF/ID holds a real instruction
- ex_ctrl  out  CTRL_W; ex_rd1, ex_rd2, ex_imm  out  32 each; ex_rs_a, ex_rt_a, ex_rd_a  out  5 each  ID/EX contents
- ex_valid  out  1  ID/EX holds a real instruction
- perf_stall_cycles, perf_bubbles  out  32 each  performance counters (see Configuration)

## Operation
- PC: rst -> RESET_PC; else StallF=1 -> hold; else pc <= pc_next.
- IF/ID, priority high to low:
  - rst -> id_instr=0 (sll $0 nop), id_pc_plus4=0, id_valid=0.
  - StallD=1 -> hold all fields. StallD beats id_branch_taken: a branch decision made while stalled uses stale operands and is ignored.
  - id_branch_taken=1 -> clear as for reset (FlushD).
  - Otherwise load if_instr / if_pc_plus4; id_valid=1.
- ID/EX, priority high to low:
  - rst or FlushE=1 -> ex_ctrl=0, all data/address fields=0, ex_valid=0. A bubble has ex_rd_a=0, so it can never match a forwarding check.
  - Otherwise load all id_* fields; ex_valid <= id_valid.
  - ID/EX has no stall input: it is always written or flushed.
- Simultaneous StallD=1 and FlushE=1 (the normal load-use / branch-hazard case): IF/ID holds and ID/EX receives a bubble in the same edge.
- StallF=1 with StallD=0 is not generated by the hazard unit. If it occurs, each register still obeys its own rule independently.
- No combinational path from inputs to outputs. All outputs are registered.

## Timing
- Reset values: pc=RESET_PC; every other output is 0 (including id_valid, ex_valid and the perf counters).
- Latency is 1 cycle per stage: a value on if_instr at edge N appears on id_instr after edge N and on ex_* after edge N+1 if there is no stall or flush.
- A stall of k cycles holds pc and IF/ID for exactly k edges and inserts exactly k ID/EX bubbles.
- Asserting rst mid-stall discards held state. Stall and flush inputs are ignored on that edge.

## Configuration
- PIPE_PERF_CNT_EN defined:
  - perf_stall_cycles increments on every non-reset edge with StallF=1.
  - perf_bubbles increments on every non-reset edge where FlushE=1, or where the FlushD condition (id_branch_taken=1 and StallD=0) holds. It increments by 1 per edge even if both occur.
  - Both counters saturate at 32'hFFFF_FFFF and clear on rst.
- PIPE_PERF_CNT_EN undefined: no counter flops; both ports are tied to 32'h0.

## Test plan
- Reset then free-run, RESET_PC=32'h0040_0000 -> pc=0x00400000 after reset. Instruction 0x8C080004 appears on id_instr 1 edge after fetch and its fields on ex_* the edge after that, with id_valid/ex_valid=1.
- Load-use: StallF=StallD=FlushE=1 for 1 cycle -> pc and id_instr unchanged for one edge; ex_ctrl=0, ex_rd_a=0, ex_valid=0 for one cycle; normal flow resumes next edge.
- Branch taken with StallD=0 -> id_instr=0 and id_valid=0 next edge; pc takes pc_next.
- id_branch_taken=1 together with StallD=1 -> IF/ID holds its value (no flush).
- Assert rst during a 3-cycle stall -> all outputs return to reset values on the next edge, pc=RESET_PC.
- With PIPE_PERF_CNT_EN: 3 stall cycles plus 1 branch flush -> perf_stall_cycles=3, perf_bubbles=4. Preload the counter to 0xFFFFFFFE, then stall 3 cycles -> counter holds at 0xFFFFFFFF. Without the macro, both counters read 0.
